// File: rtl/reg_operand_fetch.sv
// Two-stage register operand fetch: S1 drives the array read ports, S2 holds the response.
// Define OPFETCH_BYPASS_EN to forward same-cycle write-back data; otherwise a matching write stalls S1 one cycle.
module reg_operand_fetch #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int MIN_ADDR = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic [ADDR_W-1:0] reqSrcA,
   input  logic [ADDR_W-1:0] reqSrcB,
   input  logic [3:0]        reqTag,
   output logic [ADDR_W-1:0] readAddrA,
   output logic [ADDR_W-1:0] readAddrB,
   input  logic [DATA_W-1:0] readDataA,
   input  logic [DATA_W-1:0] readDataB,
   input  logic              wbValid,
   input  logic [ADDR_W-1:0] wbAddr,
   input  logic [DATA_W-1:0] wbData,
   output logic              rspValid,
   input  logic              rspReady,
   output logic [DATA_W-1:0] rspDataA,
   output logic [DATA_W-1:0] rspDataB,
   output logic [3:0]        rspTag
);

   localparam logic [ADDR_W-1:0] MIN_A = ADDR_W'(MIN_ADDR);

   logic              s1_vld_q, s1_vld_d;
   logic [ADDR_W-1:0] s1_src_a_q, s1_src_a_d;
   logic [ADDR_W-1:0] s1_src_b_q, s1_src_b_d;
   logic [3:0]        s1_tag_q, s1_tag_d;
   logic              s2_vld_q, s2_vld_d;
   logic [DATA_W-1:0] s2_data_a_q, s2_data_a_d;
   logic [DATA_W-1:0] s2_data_b_q, s2_data_b_d;
   logic [3:0]        s2_tag_q, s2_tag_d;

   logic wb_live, hit_a, hit_b, stall, byp_a, byp_b;
   logic s2_free, s1_adv, req_fire;

   function automatic logic [DATA_W-1:0] pick_operand(
      input logic [ADDR_W-1:0] src,
      input logic [DATA_W-1:0] rd,
      input logic              byp,
      input logic [DATA_W-1:0] wd
   );
      if (src < MIN_A)
         return '0;
      else if (byp)
         return wd;
      else
         return rd;
   endfunction

   // Writes below MIN_A target hard-wired zero registers, so they never forward or stall.
   assign wb_live = wbValid && (wbAddr >= MIN_A);
   assign hit_a   = wb_live && (wbAddr == s1_src_a_q);
   assign hit_b   = wb_live && (wbAddr == s1_src_b_q);

`ifdef OPFETCH_BYPASS_EN
   assign byp_a = hit_a;
   assign byp_b = hit_b;
   assign stall = 1'b0;
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
   assign stall = s1_vld_q && (hit_a || hit_b);
`endif

   assign s2_free  = !s2_vld_q || rspReady;
   assign s1_adv   = s1_vld_q && !stall && s2_free;
   assign reqReady = !s1_vld_q || s1_adv;
   assign req_fire = reqValid && reqReady;

   assign readAddrA = s1_vld_q ? s1_src_a_q : '0;
   assign readAddrB = s1_vld_q ? s1_src_b_q : '0;

   assign rspValid = s2_vld_q;
   assign rspDataA = s2_data_a_q;
   assign rspDataB = s2_data_b_q;
   assign rspTag   = s2_tag_q;

   always_comb begin
      s1_vld_d    = s1_vld_q;
      s1_src_a_d  = s1_src_a_q;
      s1_src_b_d  = s1_src_b_q;
      s1_tag_d    = s1_tag_q;
      s2_vld_d    = s2_vld_q;
      s2_data_a_d = s2_data_a_q;
      s2_data_b_d = s2_data_b_q;
      s2_tag_d    = s2_tag_q;

      if (s1_adv)
         s1_vld_d = 1'b0;
      if (req_fire) begin
         s1_vld_d   = 1'b1;
         s1_src_a_d = reqSrcA;
         s1_src_b_d = reqSrcB;
         s1_tag_d   = reqTag;
      end

      // S2 data is captured only on transfer, so a held response is immune to later writes.
      if (s1_adv) begin
         s2_vld_d    = 1'b1;
         s2_data_a_d = pick_operand(s1_src_a_q, readDataA, byp_a, wbData);
         s2_data_b_d = pick_operand(s1_src_b_q, readDataB, byp_b, wbData);
         s2_tag_d    = s1_tag_q;
      end else if (rspReady) begin
         s2_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q    <= 1'b0;
         s1_src_a_q  <= '0;
         s1_src_b_q  <= '0;
         s1_tag_q    <= '0;
         s2_vld_q    <= 1'b0;
         s2_data_a_q <= '0;
         s2_data_b_q <= '0;
         s2_tag_q    <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_src_a_q  <= s1_src_a_d;
         s1_src_b_q  <= s1_src_b_d;
         s1_tag_q    <= s1_tag_d;
         s2_vld_q    <= s2_vld_d;
         s2_data_a_q <= s2_data_a_d;
         s2_data_b_q <= s2_data_b_d;
         s2_tag_q    <= s2_tag_d;
      end
   end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed bench for reg_operand_fetch with a behavioural register array model.
module tb_reg_operand_fetch;

   logic        clk;
   logic        rst_n;
   logic        reqValid;
   logic        reqReady;
   logic [3:0]  reqSrcA, reqSrcB, reqTag;
   logic [3:0]  readAddrA, readAddrB;
   logic [15:0] readDataA, readDataB;
   logic        wbValid;
   logic [3:0]  wbAddr;
   logic [15:0] wbData;
   logic        rspValid;
   logic        rspReady;
   logic [15:0] rspDataA, rspDataB;
   logic [3:0]  rspTag;

   logic [15:0] regs [16];
   logic        model_load;

   int checks   = 0;
   int failures = 0;

   reg_operand_fetch #(.DATA_W(16), .ADDR_W(4), .MIN_ADDR(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(reqValid), .reqReady(reqReady),
      .reqSrcA(reqSrcA), .reqSrcB(reqSrcB), .reqTag(reqTag),
      .readAddrA(readAddrA), .readAddrB(readAddrB),
      .readDataA(readDataA), .readDataB(readDataB),
      .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData),
      .rspValid(rspValid), .rspReady(rspReady),
      .rspDataA(rspDataA), .rspDataB(rspDataB), .rspTag(rspTag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register array: default contents are {i,i}, with a few named values.
   always @(posedge clk) begin
      if (model_load) begin
         for (int i = 0; i < 16; i++) regs[i] <= {i[7:0], i[7:0]};
         regs[1]  <= 16'hDEAD;
         regs[5]  <= 16'h1234;
         regs[7]  <= 16'h1111;
         regs[9]  <= 16'hBEEF;
         regs[15] <= 16'h00FF;
      end else if (wbValid) begin
         regs[wbAddr] <= wbData;
      end
   end

   assign readDataA = regs[readAddrA];
   assign readDataB = regs[readAddrB];

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] t);
      reqValid = 1'b1;
      reqSrcA  = a;
      reqSrcB  = b;
      reqTag   = t;
   endtask

   initial begin
      rst_n      = 1'b0;
      model_load = 1'b1;
      reqValid   = 1'b0;
      reqSrcA    = '0;
      reqSrcB    = '0;
      reqTag     = '0;
      wbValid    = 1'b0;
      wbAddr     = '0;
      wbData     = '0;
      rspReady   = 1'b1;
      tick();
      tick();
      model_load = 1'b0;

      chk("rst_rspValid", rspValid, 0);
      chk("rst_rspDataA", rspDataA, 0);
      chk("rst_rspDataB", rspDataB, 0);
      chk("rst_rspTag", rspTag, 0);
      chk("rst_readAddrA", readAddrA, 0);
      chk("rst_readAddrB", readAddrB, 0);
      chk("rst_reqReady", reqReady, 1);
      rst_n = 1'b1;

      // Basic read, accepted at the first edge after release
      drive_req(4'd5, 4'd9, 4'd3);
      @(negedge clk);
      chk("t1_reqReady", reqReady, 1);
      tick();
      reqValid = 1'b0;
      chk("t1_rspValid_N", rspValid, 0);
      chk("t1_readAddrA", readAddrA, 5);
      chk("t1_readAddrB", readAddrB, 9);
      tick();
      chk("t1_rspValid_N1", rspValid, 1);
      chk("t1_dataA", rspDataA, 16'h1234);
      chk("t1_dataB", rspDataB, 16'hBEEF);
      chk("t1_tag", rspTag, 3);
      tick();
      chk("t1_consumed", rspValid, 0);

      // Source below MIN_ADDR reads zero
      drive_req(4'd1, 4'd15, 4'd5);
      tick();
      reqValid = 1'b0;
      tick();
      chk("t2_rspValid", rspValid, 1);
      chk("t2_dataA", rspDataA, 16'h0000);
      chk("t2_dataB", rspDataB, 16'h00FF);
      chk("t2_tag", rspTag, 5);
      tick();

      // Write-back to srcA while in S1
      drive_req(4'd7, 4'd2, 4'd6);
      tick();
      reqValid = 1'b0;
      wbValid  = 1'b1;
      wbAddr   = 4'd7;
      wbData   = 16'hA5A5;
      @(negedge clk);
      chk("t3_readAddrA", readAddrA, 7);
`ifdef OPFETCH_BYPASS_EN
      chk("t3_reqReady", reqReady, 1);
`else
      chk("t3_reqReady_stall", reqReady, 0);
`endif
      tick();
      wbValid = 1'b0;
`ifdef OPFETCH_BYPASS_EN
      chk("t3_rspValid", rspValid, 1);
`else
      chk("t3_rspValid_stall", rspValid, 0);
      tick();
      chk("t3_rspValid", rspValid, 1);
`endif
      chk("t3_dataA", rspDataA, 16'hA5A5);
      chk("t3_dataB", rspDataB, 16'h0000);
      chk("t3_tag", rspTag, 6);
      tick();
      chk("t3_consumed", rspValid, 0);

      // Write to a zero register neither bypasses nor stalls
      drive_req(4'd4, 4'd2, 4'd7);
      tick();
      reqValid = 1'b0;
      wbValid  = 1'b1;
      wbAddr   = 4'd2;
      wbData   = 16'h7777;
      @(negedge clk);
      chk("t4_reqReady", reqReady, 1);
      tick();
      wbValid = 1'b0;
      chk("t4_rspValid", rspValid, 1);
      chk("t4_dataA", rspDataA, 16'h0404);
      chk("t4_dataB", rspDataB, 16'h0000);
      tick();

      // Back-to-back requests with a stalled consumer
      rspReady = 1'b0;
      drive_req(4'd3, 4'd4, 4'd1);
      @(negedge clk);
      chk("t5_rdy_c1", reqReady, 1);
      tick();
      drive_req(4'd5, 4'd6, 4'd2);
      @(negedge clk);
      chk("t5_rdy_c2", reqReady, 1);
      chk("t5_vld_c2", rspValid, 0);
      tick();
      drive_req(4'd8, 4'd9, 4'd3);
      @(negedge clk);
      chk("t5_rdy_c3", reqReady, 0);
      chk("t5_vld_c3", rspValid, 1);
      chk("t5_tag_c3", rspTag, 1);
      chk("t5_dataA_c3", rspDataA, 16'h0303);
      tick();
      @(negedge clk);
      chk("t5_rdy_c4", reqReady, 0);
      chk("t5_tag_hold", rspTag, 1);
      chk("t5_dataA_hold", rspDataA, 16'h0303);
      chk("t5_dataB_hold", rspDataB, 16'h0404);
      chk("t5_reread", readAddrA, 5);
      tick();
      rspReady = 1'b1;
      @(negedge clk);
      chk("t5_rdy_c5", reqReady, 1);
      chk("t5_tag_c5", rspTag, 1);
      tick();
      drive_req(4'd10, 4'd11, 4'd4);
      @(negedge clk);
      chk("t5_rdy_c6", reqReady, 1);
      chk("t5_tag2", rspTag, 2);
      chk("t5_dataA2", rspDataA, 16'h1234);
      chk("t5_dataB2", rspDataB, 16'h0606);
      tick();
      reqValid = 1'b0;
      chk("t5_tag3", rspTag, 3);
      chk("t5_dataA3", rspDataA, 16'h0808);
      chk("t5_dataB3", rspDataB, 16'hBEEF);
      tick();
      chk("t5_vld4", rspValid, 1);
      chk("t5_tag4", rspTag, 4);
      chk("t5_dataA4", rspDataA, 16'h0A0A);
      chk("t5_dataB4", rspDataB, 16'h0B0B);
      tick();
      chk("t5_drained", rspValid, 0);

      // Reset with both stages full
      rspReady = 1'b0;
      drive_req(4'd3, 4'd4, 4'd9);
      tick();
      drive_req(4'd5, 4'd6, 4'd10);
      tick();
      reqValid = 1'b0;
      chk("t6_full_vld", rspValid, 1);
      chk("t6_full_addr", readAddrA, 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_vld", rspValid, 0);
      chk("t6_async_tag", rspTag, 0);
      chk("t6_async_addr", readAddrA, 0);
      tick();
      rst_n    = 1'b1;
      rspReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_no_stale", rspValid, 0);
      end
      tick();
      drive_req(4'd9, 4'd5, 4'd12);
      tick();
      reqValid = 1'b0;
      tick();
      chk("t6_post_vld", rspValid, 1);
      chk("t6_post_tag", rspTag, 12);
      chk("t6_post_dataA", rspDataA, 16'hBEEF);
      chk("t6_post_dataB", rspDataB, 16'h1234);
      tick();
      chk("t6_post_drained", rspValid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_operand_fetch.md
REG_OPERAND_FETCH -- requirements
Module: reg_operand_fetch

Interface
REQ-001 Parameter DATA_W, 16, register and operand data width.
REQ-002 Parameter ADDR_W, 4, register address width.
REQ-003 Parameter MIN_ADDR, 3, lowest implemented register index; lower indices read as zero.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 reqValid  input  1  operand request present.
REQ-007 reqReady  output  1  request accepted when reqValid && reqReady at rising edge.
REQ-008 reqSrcA, reqSrcB  input  ADDR_W each  source register indices.
REQ-009 reqTag  input  4  opaque request tag, returned unchanged.
REQ-010 readAddrA, readAddrB  output  ADDR_W each  address ports to the register array.
REQ-011 readDataA, readDataB  input  DATA_W each  combinational read data from the register array.
REQ-012 wbValid, wbAddr (ADDR_W), wbData (DATA_W)  input  snoop of the array write port, written at the same rising edge.
REQ-013 rspValid  output  1  operand response present.
REQ-014 rspReady  input  1  response consumed when rspValid && rspReady at rising edge.
REQ-015 rspDataA, rspDataB  output  DATA_W each; rspTag  output  4.

Function
REQ-016 Two stages: S1 (address/read), S2 (response register); each holds one entry with a valid bit.
REQ-017 Accepted request SHALL load S1 with srcA, srcB, tag at that edge.
REQ-018 readAddrA/readAddrB SHALL equal S1 srcA/srcB every cycle; 0 when S1 empty.
REQ-019 S1 SHALL advance to S2 when S1 valid, no interlock (REQ-027), and S2 empty or being consumed that cycle.
REQ-020 Operand captured into S2: 0 if source < MIN_ADDR; else bypass value (REQ-026) if applicable; else readData.
REQ-021 Latency: request accepted at edge N SHALL have rspValid high after edge N+1 when rspReady held high.
REQ-022 reqReady SHALL be high iff S1 empty or S1 advancing that cycle; back-to-back requests SHALL sustain one per cycle.
REQ-023 rspValid high with rspReady low: rspDataA/B and rspTag SHALL hold stable; S1 SHALL hold and re-read each cycle.
REQ-024 Response data is a snapshot at S1->S2 transfer; later writes SHALL NOT alter a held S2 entry.
REQ-025 Order: responses SHALL leave in request acceptance order; no entry dropped or duplicated.

Configuration
REQ-026 Macro OPFETCH_BYPASS_EN defined: when wbValid && wbAddr == source && wbAddr >= MIN_ADDR in the transfer cycle, captured operand SHALL be wbData; srcA and srcB bypass independently.
REQ-027 Macro undefined: no bypass; if wbValid && wbAddr equals S1 srcA or srcB (and >= MIN_ADDR), S1 SHALL stall exactly that cycle and transfer next cycle reading committed data.
REQ-028 Either build: writes to addresses < MIN_ADDR SHALL neither bypass nor stall.

Reset
REQ-029 rst_n low SHALL immediately clear S1 and S2 valid; rspValid=0, rspDataA/B=0, rspTag=0, readAddrA/B=0, reqReady=1 after release.
REQ-030 Reset mid-operation SHALL discard in-flight entries; no response for them after release.
REQ-031 First request SHALL be acceptable at first rising edge with rst_n high.

Verification
REQ-032 Reg5=0x1234, Reg9=0xBEEF; request srcA=5 srcB=9 tag=3, rspReady=1 -> rspValid after edge N+1, A=0x1234 B=0xBEEF tag=3.
REQ-033 Request srcA=1 srcB=15 (Reg15=0x00FF) -> A=0x0000, B=0x00FF.
REQ-034 Request srcA=7 in S1 while wbValid wbAddr=7 wbData=0xA5A5 (Reg7 old 0x1111) -> A=0xA5A5; with bypass same latency, without bypass one extra cycle.
REQ-035 Four back-to-back requests tags 1..4, rspReady low 3 cycles then high -> reqReady drops while stalled, responses tags 1,2,3,4 in order, data stable while held.
REQ-036 rst_n pulsed low with S1 and S2 full -> rspValid=0 immediately, no stale response after release, next request served normally.
